// File: rtl/mlx90640_pkg.sv
// mlx90640_pkg: shared constants and types for the MLX90640 frame assembler.
package mlx90640_pkg;

    localparam int N_WORDS = 768;
    localparam int ADDR_W  = 10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic subpage_t;

endpackage

// File: rtl/mlx90640_frame_assembler.sv
// mlx90640_frame_assembler: keeps the chess-pattern half of a subpage stream,
// writes it to an external frame RAM and tracks the subpage signed min/max.
module mlx90640_frame_assembler
    import mlx90640_pkg::*;
#(
    parameter int p_cols   = 32,
    parameter int p_rows   = 24,
    parameter int p_data_w = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_subpage,
    input  logic                i_valid,
    input  logic [p_data_w-1:0] i_data,
    output logic                o_ready,
    output logic                o_we,
    output logic [ADDR_W-1:0]   o_waddr,
    output logic [p_data_w-1:0] o_wdata,
    output logic                o_busy,
    output logic                o_done,
    output logic [p_data_w-1:0] o_min,
    output logic [p_data_w-1:0] o_max,
    output logic                o_frame_valid
);

    if (p_cols * p_rows != N_WORDS) begin : g_geom_check
        $error("p_cols*p_rows must equal N_WORDS");
    end

    localparam logic [p_data_w-1:0] MIN_INIT = {1'b0, {(p_data_w-1){1'b1}}};
    localparam logic [p_data_w-1:0] MAX_INIT = {1'b1, {(p_data_w-1){1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     n_q, n_d;
    subpage_t              sub_q, sub_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     waddr_q, waddr_d;
    logic [p_data_w-1:0]   wdata_q, wdata_d;
    logic [p_data_w-1:0]   run_min_q, run_min_d, run_max_q, run_max_d;
    logic [p_data_w-1:0]   min_q, min_d, max_q, max_d;
    logic [1:0]            mask_q, mask_d;
    logic                  accept, keep, last;
    logic [p_data_w-1:0]   min_next, max_next;

    // Parity of row+col equals the xor of their low bits.
    assign keep     = (1'(n_q / ADDR_W'(p_cols)) ^ 1'(n_q % ADDR_W'(p_cols))) == sub_q;
    assign accept   = (state_q == RUN) && i_valid;
    assign last     = n_q == ADDR_W'(N_WORDS - 1);
    assign min_next = (keep && $signed(i_data) < $signed(run_min_q)) ? i_data : run_min_q;
    assign max_next = (keep && $signed(i_data) > $signed(run_max_q)) ? i_data : run_max_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        sub_d     = sub_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        min_d     = min_q;
        max_d     = max_q;
        mask_d    = mask_q;
        case (state_q)
            IDLE: if (i_start) begin
                state_d   = RUN;
                n_d       = '0;
                sub_d     = i_subpage;
                run_min_d = MIN_INIT;
                run_max_d = MAX_INIT;
            end
            RUN: if (accept) begin
                n_d       = n_q + 1'b1;
                we_d      = keep;
                waddr_d   = n_q;
                wdata_d   = i_data;
                run_min_d = min_next;
                run_max_d = max_next;
                // Publish results on the edge into DONE so they are visible with o_done.
                if (last) begin
                    state_d        = DONE;
                    min_d          = min_next;
                    max_d          = max_next;
                    mask_d[sub_q]  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            sub_q     <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            run_min_q <= '0;
            run_max_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            sub_q     <= sub_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
            mask_q    <= mask_d;
        end
    end

    assign o_ready       = state_q == RUN;
    assign o_busy        = state_q != IDLE;
    assign o_done        = state_q == DONE;
    assign o_we          = we_q;
    assign o_waddr       = waddr_q;
    assign o_wdata       = wdata_q;
    assign o_min         = min_q;
    assign o_max         = max_q;
    assign o_frame_valid = &mask_q;

endmodule

// File: tb/tb_mlx90640_frame_assembler.sv
// tb_mlx90640_frame_assembler: directed checks of subpage assembly, min/max,
// frame-valid, stalls, ignored restarts and mid-run reset.
module tb_mlx90640_frame_assembler;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_subpage = 1'b0;
    logic        i_valid = 1'b0;
    logic [15:0] i_data = '0;
    logic        o_ready, o_we, o_busy, o_done, o_frame_valid;
    logic [9:0]  o_waddr;
    logic [15:0] o_wdata, o_min, o_max;

    mlx90640_frame_assembler dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_subpage(i_subpage),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_we(o_we),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy(o_busy), .o_done(o_done),
        .o_min(o_min), .o_max(o_max), .o_frame_valid(o_frame_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] dat [768];
    logic [9:0]  alog [4096];
    logic [15:0] dlog [4096];
    int          wtot = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [15:0] done_min, done_max;
    logic        done_fv, done_fv_prev, fv_prev = 1'b0;

    always @(negedge clk) begin
        if (o_we && wtot < 4096) begin
            alog[wtot] = o_waddr;
            dlog[wtot] = o_wdata;
            wtot++;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_min = o_min;
            done_max = o_max;
            done_fv = o_frame_valid;
            done_fv_prev = fv_prev;
        end
        fv_prev = o_frame_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int first_acc;

    task automatic run(input bit s, input bit tog, input int inj_at, input int abort_at);
        int k = 0;
        int g = 0;
        int d0 = done_cnt;
        int w0;
        bit acc;
        first_acc = -1;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_subpage = s;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_subpage = !s;
        while (k < 768 && g < 4000) begin
            i_valid = tog ? 1'($urandom_range(0, 1)) : 1'b1;
            i_data = dat[k];
            i_start = (k == inj_at);
            if (k == abort_at) begin
                #1 i_rst_n = 1'b0;
                #1;
                chk("rst_ctl", {27'd0, o_we, o_busy, o_ready, o_done, o_frame_valid}, 32'd0);
                chk("rst_waddr_wdata", {o_waddr, o_wdata}, 32'd0);
                chk("rst_min_max", {o_min, o_max}, 32'd0);
                i_valid = 1'b0;
                i_start = 1'b0;
                w0 = wtot;
                @(posedge clk); @(posedge clk); #1;
                i_rst_n = 1'b1;
                @(posedge clk); @(posedge clk); #1;
                chk("abort_no_write", wtot, w0);
                chk("abort_no_done", done_cnt, d0);
                return;
            end
            acc = i_valid && o_ready;
            if (acc && first_acc < 0) first_acc = cyc;
            @(posedge clk);
            if (acc) k++;
            #1 g++;
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        if (k < 768) chk("accept_timeout", k, 768);
        g = 0;
        while (done_cnt == d0 && g < 20) begin
            @(negedge clk); #1 g++;
        end
        chk("done_once", done_cnt - d0, 1);
        @(posedge clk); @(posedge clk); #1;
        chk("single_done", done_cnt - d0, 1);
        chk("idle_after", {o_busy, o_ready}, 0);
    endtask

    task automatic verify(input string tag, input bit s, input int base, input bit chk_data);
        int idx = 0;
        int bad = 0;
        for (int n = 0; n < 768; n++) begin
            if (((n / 32 + n % 32) % 2) == s) begin
                if (alog[base + idx] !== 10'(n)) bad++;
                if (chk_data && dlog[base + idx] !== dat[n]) bad++;
                idx++;
            end
        end
        chk({tag, "_count"}, wtot - base, 384);
        chk({tag, "_addr"}, bad, 0);
    endtask

    int base;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {27'd0, o_we, o_busy, o_ready, o_done, o_frame_valid}, 32'd0);
        chk("reset_min_max", {o_min, o_max}, 32'd0);
        i_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", o_ready, 1'b0);

        for (int n = 0; n < 768; n++) dat[n] = 16'(n);
        base = wtot;
        run(1'b0, 1'b0, -1, -1);
        verify("sp0", 1'b0, base, 1'b1);
        chk("done_cycle", done_cyc - first_acc + 1, 769);
        chk("sp0_min", done_min, 16'h0000);
        chk("sp0_max", done_max, 16'd767);
        chk("sp0_fv_done", done_fv, 1'b0);
        chk("sp0_fv_after", o_frame_valid, 1'b0);
        chk("first_addr_sp0", alog[base], 0);
        chk("addr_32_33", {alog[base + 15], alog[base + 16]}, {10'd30, 10'd33});

        for (int n = 0; n < 768; n++) dat[n] = 16'h0000;
        dat[1] = 16'hFFFB;
        dat[766] = 16'd300;
        dat[2] = 16'h8000;
        base = wtot;
        run(1'b1, 1'b0, -1, -1);
        verify("sp1", 1'b1, base, 1'b1);
        chk("sp1_min", done_min, 16'hFFFB);
        chk("sp1_max", done_max, 16'h012C);
        chk("sp1_fv_before", done_fv_prev, 1'b0);
        chk("sp1_fv_done", done_fv, 1'b1);
        chk("min_held", o_min, 16'hFFFB);

        for (int n = 0; n < 768; n++) dat[n] = 16'(n);
        base = wtot;
        run(1'b0, 1'b1, -1, -1);
        verify("stall", 1'b0, base, 1'b1);
        chk("fv_sticky", o_frame_valid, 1'b1);

        base = wtot;
        run(1'b0, 1'b0, 100, -1);
        verify("restart_ign", 1'b0, base, 1'b1);

        run(1'b0, 1'b0, -1, 400);
        base = wtot;
        run(1'b1, 1'b0, -1, -1);
        verify("after_rst", 1'b1, base, 1'b1);
        chk("after_rst_first", alog[base], 1);
        chk("after_rst_fv", o_frame_valid, 1'b0);
        chk("after_rst_max", done_max, 16'd766);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
